// File: rtl/spi_transfer_sequencer.sv
// ============================================================================
// Module      : spi_transfer_sequencer
// Description : TX/RX FIFO-buffered word sequencer driving an SPI master core.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module spi_transfer_sequencer #(
    parameter int SPI_DATA_WIDTH  = 8,
    parameter int FIFO_ADDR_WIDTH = 3
) (
    input  logic                       i_clock,
    input  logic                       i_reset_n,
    input  logic                       i_tx_valid,
    output logic                       o_tx_ready,
    input  logic [SPI_DATA_WIDTH-1:0]  i_tx_data,
    output logic                       o_rx_valid,
    input  logic                       i_rx_ready,
    output logic [SPI_DATA_WIDTH-1:0]  o_rx_data,
    output logic [FIFO_ADDR_WIDTH:0]   o_tx_level,
    output logic [FIFO_ADDR_WIDTH:0]   o_rx_level,
    output logic                       o_busy,
    output logic                       o_spi_enable,
    output logic [SPI_DATA_WIDTH-1:0]  o_spi_data_in,
    input  logic [SPI_DATA_WIDTH-1:0]  i_spi_data_out,
    input  logic                       i_spi_done
);

    localparam int c_DEPTH = 1 << FIFO_ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LAUNCH    = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    state_t                      r_state;
    logic [SPI_DATA_WIDTH-1:0]   r_spi_data;
    logic                        r_spi_enable;
    logic                        r_busy;

    logic [SPI_DATA_WIDTH-1:0]   r_tx_mem [c_DEPTH];
    logic [SPI_DATA_WIDTH-1:0]   r_rx_mem [c_DEPTH];
    logic [FIFO_ADDR_WIDTH:0]    r_tx_wptr, r_tx_rptr;
    logic [FIFO_ADDR_WIDTH:0]    r_rx_wptr, r_rx_rptr;

    logic w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
    logic w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;

    // Full when the wrap bits differ but the addresses coincide.
    assign w_tx_empty = (r_tx_wptr == r_tx_rptr);
    assign w_tx_full  = (r_tx_wptr[FIFO_ADDR_WIDTH] != r_tx_rptr[FIFO_ADDR_WIDTH]) &&
                        (r_tx_wptr[FIFO_ADDR_WIDTH-1:0] == r_tx_rptr[FIFO_ADDR_WIDTH-1:0]);
    assign w_rx_empty = (r_rx_wptr == r_rx_rptr);
    assign w_rx_full  = (r_rx_wptr[FIFO_ADDR_WIDTH] != r_rx_rptr[FIFO_ADDR_WIDTH]) &&
                        (r_rx_wptr[FIFO_ADDR_WIDTH-1:0] == r_rx_rptr[FIFO_ADDR_WIDTH-1:0]);

    assign w_tx_push = i_tx_valid && !w_tx_full;
    assign w_tx_pop  = (r_state == S_IDLE) && !w_tx_empty && !w_rx_full;
    assign w_rx_push = (r_state == S_WAIT_DONE) && i_spi_done;
    assign w_rx_pop  = !w_rx_empty && i_rx_ready;

    assign o_tx_ready    = !w_tx_full;
    assign o_rx_valid    = !w_rx_empty;
    assign o_rx_data     = r_rx_mem[r_rx_rptr[FIFO_ADDR_WIDTH-1:0]];
    assign o_tx_level    = r_tx_wptr - r_tx_rptr;
    assign o_rx_level    = r_rx_wptr - r_rx_rptr;
    assign o_busy        = r_busy;
    assign o_spi_enable  = r_spi_enable;
    assign o_spi_data_in = r_spi_data;

    always_ff @(posedge i_clock) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wptr[FIFO_ADDR_WIDTH-1:0]] <= i_tx_data;
        end
        if (w_rx_push) begin
            r_rx_mem[r_rx_wptr[FIFO_ADDR_WIDTH-1:0]] <= i_spi_data_out;
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_tx_wptr <= '0;
            r_tx_rptr <= '0;
            r_rx_wptr <= '0;
            r_rx_rptr <= '0;
        end else begin
            if (w_tx_push) r_tx_wptr <= r_tx_wptr + 1'b1;
            if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + 1'b1;
            if (w_rx_push) r_rx_wptr <= r_rx_wptr + 1'b1;
            if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + 1'b1;
        end
    end

    // Launch only with RX space reserved, so a completed word is never dropped.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state      <= S_IDLE;
            r_spi_data   <= '0;
            r_spi_enable <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_spi_enable <= 1'b0;
                    if (w_tx_pop) begin
                        r_state      <= S_LAUNCH;
                        r_spi_data   <= r_tx_mem[r_tx_rptr[FIFO_ADDR_WIDTH-1:0]];
                        r_spi_enable <= 1'b1;
                        r_busy       <= 1'b1;
                    end
                end
                S_LAUNCH: begin
                    r_state      <= S_WAIT_DONE;
                    r_spi_enable <= 1'b0;
                end
                S_WAIT_DONE: begin
                    r_spi_enable <= 1'b0;
                    if (i_spi_done) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_spi_enable <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_spi_transfer_sequencer.sv
// ============================================================================
// Module      : tb_spi_transfer_sequencer
// Description : Randomized scoreboard bench for spi_transfer_sequencer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_spi_transfer_sequencer;

    localparam int W     = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tx_valid;
    logic          tx_ready;
    logic [W-1:0]  tx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [W-1:0]  rx_data;
    logic [AW:0]   tx_level;
    logic [AW:0]   rx_level;
    logic          busy;
    logic          spi_en;
    logic [W-1:0]  spi_din;
    logic [W-1:0]  spi_dout = '0;
    logic          spi_done;

    always #5 clk = ~clk;

    spi_transfer_sequencer #(.SPI_DATA_WIDTH(W), .FIFO_ADDR_WIDTH(AW)) dut (
        .i_clock       (clk),
        .i_reset_n     (rst_n),
        .i_tx_valid    (tx_valid),
        .o_tx_ready    (tx_ready),
        .i_tx_data     (tx_data),
        .o_rx_valid    (rx_valid),
        .i_rx_ready    (rx_ready),
        .o_rx_data     (rx_data),
        .o_tx_level    (tx_level),
        .o_rx_level    (rx_level),
        .o_busy        (busy),
        .o_spi_enable  (spi_en),
        .o_spi_data_in (spi_din),
        .i_spi_data_out(spi_dout),
        .i_spi_done    (spi_done)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: word queues plus "transfer outstanding" bookkeeping.
    logic [W-1:0] key = '0;
    logic [W-1:0] m_txq[$];
    logic [W-1:0] m_rxq[$];
    bit           m_en     = 1'b0;
    bit           m_flight = 1'b0;
    logic [W-1:0] m_cur    = '0;

    always @(posedge clk) begin : model
        bit e_push, e_pop, e_done, e_start;
        if (!rst_n) begin
            m_txq.delete();
            m_rxq.delete();
            m_en     = 1'b0;
            m_flight = 1'b0;
            m_cur    = '0;
        end else begin
            e_push  = tx_valid && (m_txq.size() < DEPTH);
            e_pop   = rx_ready && (m_rxq.size() > 0);
            e_done  = m_flight && !m_en && spi_done;
            e_start = !m_flight && (m_txq.size() > 0) && (m_rxq.size() < DEPTH);
            m_en = e_start;
            if (e_pop) void'(m_rxq.pop_front());
            if (e_done) begin
                m_rxq.push_back(m_cur ^ key);
                m_flight = 1'b0;
            end
            if (e_start) begin
                m_cur    = m_txq.pop_front();
                m_flight = 1'b1;
            end
            if (e_push) m_txq.push_back(tx_data);
        end
    end

    // Cycle checks against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("tx_ready", int'(tx_ready), int'(m_txq.size() < DEPTH));
            chk("tx_level", int'(tx_level), m_txq.size());
            chk("rx_level", int'(rx_level), m_rxq.size());
            chk("rx_valid", int'(rx_valid), int'(m_rxq.size() > 0));
            chk("spi_enable", int'(spi_en), int'(m_en));
            chk("busy", int'(busy), int'(m_flight));
            chk("spi_data_in", int'(spi_din), int'(m_cur));
        end
    end

    // Scoreboard: expected RX words queued at TX acceptance, popped on RX handshake.
    logic [W-1:0] sb_q[$];
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
        end else if (chk_en) begin
            if (tx_valid && (m_txq.size() < DEPTH)) sb_q.push_back(tx_data ^ key);
            if (rx_valid && rx_ready) begin
                if (sb_q.size() == 0) chk("rx_unexpected", int'(rx_data), -1);
                else                  chk("rx_data", int'(rx_data), int'(sb_q.pop_front()));
            end
        end
    end

    // SPI master stand-in: returns (sent word ^ key) after a random delay.
    int           sl_cnt = 0;
    int           sl_lo  = 1;
    int           sl_hi  = 4;
    logic [W-1:0] sl_data = '0;
    bit           sl_done = 1'b0;
    bit           spur    = 1'b0;
    assign spi_done = sl_done | spur;

    always @(negedge clk) begin
        sl_done = 1'b0;
        if (sl_cnt > 0) begin
            sl_cnt--;
            if (sl_cnt == 0) begin
                sl_done  = 1'b1;
                spi_dout = sl_data;
            end
        end
        if (spi_en === 1'b1) begin
            sl_cnt  = $urandom_range(sl_hi, sl_lo);
            sl_data = spi_din ^ key;
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [W-1:0] d);
        int n;
        n = 0;
        tx_valid = 1'b1;
        tx_data  = d;
        while (!tx_ready && n < 2000) begin
            step(1);
            n++;
        end
        if (n >= 2000) chk("push_timeout", n, 0);
        step(1);
        tx_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        rx_ready = 1'b1;
        while ((m_txq.size() > 0 || m_rxq.size() > 0 || m_flight) && n < 3000) begin
            step(1);
            n++;
        end
        if (n >= 3000) chk("drain_timeout", n, 0);
        step(2);
    endtask

    initial begin
        rst_n    = 1'b0;
        tx_valid = 1'b1;
        tx_data  = 8'h33;
        rx_ready = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        step(1);
        rst_n    = 1'b1;
        tx_valid = 1'b0;
        rx_ready = 1'b1;
        step(3);

        // Single loopback transfer
        push(8'hAA);
        drain();

        // Burst with a slow master so the TX FIFO fills
        sl_lo = 10; sl_hi = 20;
        for (int i = 1; i <= 10; i++) push(W'(i));
        drain();

        // RX back-pressure
        sl_lo = 1; sl_hi = 3;
        rx_ready = 1'b0;
        for (int i = 0; i < 10; i++) push(W'($urandom));
        step(150);
        rx_ready = 1'b1;
        step(1);
        rx_ready = 1'b0;
        step(40);
        drain();

        // Spurious done while idle
        spur = 1'b1;
        step(1);
        spur = 1'b0;
        step(3);

        // Reset while waiting for done; the late done must be ignored
        sl_lo = 12; sl_hi = 12;
        push(8'h5C);
        step(4);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(20);
        drain();

        // Randomized traffic with a non-trivial return transform
        key   = 8'h5A;
        sl_lo = 1; sl_hi = 8;
        for (int c = 0; c < 1500; c++) begin
            tx_valid = ($urandom_range(1, 0) == 1);
            tx_data  = W'($urandom);
            rx_ready = ($urandom_range(9, 0) < 7);
            step(1);
        end
        tx_valid = 1'b0;
        drain();
        chk("scoreboard_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
